// File: rtl/bp_be_fe_queue_ckpt_pkg.sv
// rtl/bp_be_fe_queue_ckpt_pkg.sv - FE->BE queue packet types and widths
// Purpose: FE queue packet layout and message-type decode shared by the
//          checkpointed fetch queue, its interface and its clients.
// Ports:   none (package).
package bp_be_fe_queue_ckpt_pkg;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_instr_fetch        = 2'd0,
    e_itlb_miss          = 2'd1,
    e_instr_page_fault   = 2'd2,
    e_instr_access_fault = 2'd3
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e             msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

  // Anything other than a plain fetch must be handled as an exception by the BE.
  function automatic logic is_exception(input bp_fe_queue_s pkt);
    return pkt.msg_type != e_instr_fetch;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_ckpt_if.sv
// rtl/bp_be_fe_queue_ckpt_if.sv - FE->BE enqueue handshake bundle
// Purpose: groups the FE packet, its valid and the queue's ready.
// Ports:   master (FE side): drives fe_queue/fe_queue_v, samples fe_queue_ready.
//          slave  (BE side): samples fe_queue/fe_queue_v, drives fe_queue_ready.
interface bp_be_fe_queue_ckpt_if;
  import bp_be_fe_queue_ckpt_pkg::*;

  bp_fe_queue_s fe_queue;
  logic         fe_queue_v;
  logic         fe_queue_ready;

  modport master (output fe_queue, output fe_queue_v, input fe_queue_ready);
  modport slave  (input fe_queue, input fe_queue_v, output fe_queue_ready);

endinterface

// File: rtl/bp_be_fe_queue_ckpt_ptrs.sv
// rtl/bp_be_fe_queue_ckpt_ptrs.sv - write/speculative-read/checkpoint pointer set
// Purpose: three wrap-bit pointers for a checkpointed circular queue, with
//          full/empty/occupancy derived from them. Reusable for other queues.
// Ports:   clk_i, reset_i (async, active-high)
//          clr_i, enq_i, yumi_i, deq_i, roll_i : pointer update requests
//          waddr_o, raddr_o                    : storage indices (wptr, rptr)
//          full_o, empty_o, rd_v_o, count_o    : status from registered state
module bp_be_ckpt_ptrs #(
  parameter  int els_p        = 8,
  localparam int ptr_width_lp = $clog2(els_p) + 1,
  localparam int idx_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    enq_i,
  input  logic                    yumi_i,
  input  logic                    deq_i,
  input  logic                    roll_i,
  output logic [idx_width_lp-1:0] waddr_o,
  output logic [idx_width_lp-1:0] raddr_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    rd_v_o,
  output logic [ptr_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0] wptr_q, rptr_q, cptr_q;
  logic [ptr_width_lp-1:0] wptr_d, rptr_d, cptr_d;

  // Priority: clear beats everything; roll targets the post-deq checkpoint
  // and overrides a same-cycle issue.
  always_comb begin
    cptr_d = cptr_q + ptr_width_lp'(deq_i);
    rptr_d = roll_i ? cptr_d : (rptr_q + ptr_width_lp'(yumi_i));
    wptr_d = wptr_q + ptr_width_lp'(enq_i);
    if (clr_i) begin
      cptr_d = '0;
      rptr_d = '0;
      wptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // The wrap bit distinguishes full (difference == els) from empty.
  assign count_o = wptr_q - cptr_q;
  assign full_o  = (count_o == ptr_width_lp'(els_p));
  assign empty_o = (wptr_q == cptr_q);
  assign rd_v_o  = (rptr_q != wptr_q);
  assign waddr_o = wptr_q[idx_width_lp-1:0];
  assign raddr_o = rptr_q[idx_width_lp-1:0];

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !rd_v_o))
        else $error("bp_be_ckpt_ptrs: yumi_i with no valid entry");
      assert (!(deq_i && (cptr_q == rptr_q)))
        else $error("bp_be_ckpt_ptrs: deq_i on an entry that was never issued");
    end
  end

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// rtl/bp_be_fe_queue_ckpt.sv - checkpointed FE->BE fetch queue (BE receiver)
// Purpose: buffers FE packets; issue reads speculatively, commit advances the
//          checkpoint, roll rewinds issue to the checkpoint, clr flushes.
// Ports:   clk_i, reset_i (async, active-high)
//          fe_queue_if     : slave side of the FE enqueue handshake
//          fe_queue_o, fe_queue_v_o, fe_queue_yumi_i : issue port
//          exception_v_o   : head entry is a non-fetch message
//          clr_i, roll_i, deq_i : flush / rewind / commit
//          empty_o, count_o     : occupancy (write minus checkpoint)
module bp_be_fe_queue_ckpt
  import bp_be_fe_queue_ckpt_pkg::*;
#(
  parameter  int fe_queue_els_p = 8,
  localparam int ptr_width_lp   = $clog2(fe_queue_els_p) + 1,
  localparam int idx_width_lp   = $clog2(fe_queue_els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_be_fe_queue_ckpt_if.slave     fe_queue_if,
  output bp_fe_queue_s             fe_queue_o,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_yumi_i,
  output logic                     exception_v_o,
  input  logic                     clr_i,
  input  logic                     roll_i,
  input  logic                     deq_i,
  output logic                     empty_o,
  output logic [ptr_width_lp-1:0]  count_o
);

  logic [idx_width_lp-1:0] waddr, raddr;
  logic                    full;
  logic                    enq;

  bp_fe_queue_s mem_q [fe_queue_els_p];

  // A packet arriving in a clear cycle is dropped even though ready was shown.
  assign enq = fe_queue_if.fe_queue_v & fe_queue_if.fe_queue_ready & ~clr_i;

  bp_be_ckpt_ptrs #(.els_p(fe_queue_els_p)) ptrs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (clr_i),
    .enq_i   (enq),
    .yumi_i  (fe_queue_yumi_i),
    .deq_i   (deq_i),
    .roll_i  (roll_i),
    .waddr_o (waddr),
    .raddr_o (raddr),
    .full_o  (full),
    .empty_o (empty_o),
    .rd_v_o  (fe_queue_v_o),
    .count_o (count_o)
  );

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[waddr] <= fe_queue_if.fe_queue;
  end

  assign fe_queue_if.fe_queue_ready = ~full;
  assign fe_queue_o    = mem_q[raddr];
  assign exception_v_o = fe_queue_v_o & is_exception(fe_queue_o);

  // Tracks a stalled offer so a changing payload under backpressure is flagged.
  logic         stall_q;
  bp_fe_queue_s stall_data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      stall_q      <= fe_queue_if.fe_queue_v & ~fe_queue_if.fe_queue_ready;
      stall_data_q <= fe_queue_if.fe_queue;
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i && stall_q && fe_queue_if.fe_queue_v) begin
      assert (fe_queue_if.fe_queue == stall_data_q)
        else $warning("bp_be_fe_queue_ckpt: FE packet changed while stalled");
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// tb/tb_bp_be_fe_queue_ckpt.sv - directed self-checking bench for bp_be_fe_queue_ckpt
module tb_bp_be_fe_queue_ckpt;
  import bp_be_fe_queue_ckpt_pkg::*;

  logic         clk_i = 1'b0;
  logic         reset_i;
  bp_fe_queue_s fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         exception_v_o;
  logic         clr_i, roll_i, deq_i;
  logic         empty_o;
  logic [3:0]   count_o;

  int errors = 0;
  int checks = 0;

  bp_be_fe_queue_ckpt_if fe_if ();

  bp_be_fe_queue_ckpt #(.fe_queue_els_p(8)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .fe_queue_if     (fe_if),
    .fe_queue_o      (fe_queue_o),
    .fe_queue_v_o    (fe_queue_v_o),
    .fe_queue_yumi_i (fe_queue_yumi_i),
    .exception_v_o   (exception_v_o),
    .clr_i           (clr_i),
    .roll_i          (roll_i),
    .deq_i           (deq_i),
    .empty_o         (empty_o),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bp_fe_queue_s mk(input bp_fe_msg_type_e mt, input logic [38:0] pc);
    bp_fe_queue_s p;
    p.msg_type = mt;
    p.pc       = pc;
    p.instr    = pc[31:0] ^ 32'h5a5a_0013;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [38:0] sb_q[$];
  int          iss;
  int          sent;
  int          cyc;
  logic        v, y, d, rdy;

  initial begin
    reset_i            = 1'b1;
    fe_if.fe_queue     = '0;
    fe_if.fe_queue_v   = 1'b0;
    fe_queue_yumi_i    = 1'b0;
    clr_i              = 1'b0;
    roll_i             = 1'b0;
    deq_i              = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;

    // 1. reset then idle
    for (int i = 0; i < 10; i++) begin
      check("t1_ready", fe_if.fe_queue_ready, 1);
      check("t1_v", fe_queue_v_o, 0);
      check("t1_empty", empty_o, 1);
      check("t1_count", count_o, 0);
      tick();
    end

    // 2. fill then drain
    fe_if.fe_queue_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_ready_fill", fe_if.fe_queue_ready, 1);
      fe_if.fe_queue = mk(e_instr_fetch, 39'h8000_0000 + 39'(4 * i));
      tick();
    end
    check("t2_full_ready", fe_if.fe_queue_ready, 0);
    check("t2_full_count", count_o, 8);
    fe_if.fe_queue = mk(e_instr_fetch, 39'h8000_0020);
    tick();
    check("t2_ninth_count", count_o, 8);
    check("t2_ninth_head", fe_queue_o.pc, 39'h8000_0000);
    fe_if.fe_queue_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_v", fe_queue_v_o, 1);
      check("t2_drain_pc", fe_queue_o.pc, 39'h8000_0000 + 39'(4 * i));
      fe_queue_yumi_i = 1'b1;
      deq_i = (i > 0);
      tick();
    end
    fe_queue_yumi_i = 1'b0;
    deq_i = 1'b1;
    tick();
    deq_i = 1'b0;
    check("t2_empty", empty_o, 1);
    check("t2_count0", count_o, 0);
    check("t2_v0", fe_queue_v_o, 0);

    // 3. speculate and roll back
    fe_if.fe_queue_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fe_if.fe_queue = mk(e_instr_fetch, 39'h9000_0000 + 39'(4 * i));
      tick();
    end
    fe_if.fe_queue_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_issue_pc", fe_queue_o.pc, 39'h9000_0000 + 39'(4 * i));
      fe_queue_yumi_i = 1'b1;
      tick();
    end
    fe_queue_yumi_i = 1'b0;
    deq_i = 1'b1;
    tick();
    deq_i = 1'b0;
    check("t3_pre_roll_pc", fe_queue_o.pc, 39'h9000_000c);
    roll_i = 1'b1;
    tick();
    roll_i = 1'b0;
    check("t3_roll_pc", fe_queue_o.pc, 39'h9000_0004);
    check("t3_roll_v", fe_queue_v_o, 1);
    check("t3_roll_count", count_o, 4);
    for (int i = 1; i < 5; i++) begin
      check("t3_reissue_pc", fe_queue_o.pc, 39'h9000_0000 + 39'(4 * i));
      fe_queue_yumi_i = 1'b1;
      tick();
    end
    fe_queue_yumi_i = 1'b0;
    check("t3_reissue_v0", fe_queue_v_o, 0);
    deq_i = 1'b1;
    repeat (4) tick();
    deq_i = 1'b0;
    check("t3_empty", empty_o, 1);

    // 4. clear collides with an incoming packet
    fe_if.fe_queue_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fe_if.fe_queue = mk(e_instr_fetch, 39'ha000_0000 + 39'(4 * i));
      tick();
    end
    check("t4_count6", count_o, 6);
    fe_if.fe_queue = mk(e_instr_fetch, 39'h1234);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    fe_if.fe_queue_v = 1'b0;
    check("t4_clr_v", fe_queue_v_o, 0);
    check("t4_clr_count", count_o, 0);
    check("t4_clr_empty", empty_o, 1);
    check("t4_clr_ready", fe_if.fe_queue_ready, 1);

    // 5. random stream with scoreboard; pointers wrap several times
    iss  = 0;
    sent = 0;
    cyc  = 0;
    while (!(sent == 40 && sb_q.size() == 0) && cyc < 3000) begin
      check("t5_v", fe_queue_v_o, (iss < sb_q.size()));
      check("t5_count", count_o, sb_q.size());
      check("t5_ready", fe_if.fe_queue_ready, (sb_q.size() < 8));
      check("t5_full_and_empty", (!fe_if.fe_queue_ready) && empty_o, 0);
      if (iss < sb_q.size()) check("t5_pc", fe_queue_o.pc, sb_q[iss]);
      rdy = (sb_q.size() < 8);
      v   = (sent < 40) && ($urandom_range(0, 2) != 0);
      y   = (iss < sb_q.size()) && ($urandom_range(0, 1) != 0);
      d   = (iss > 0) && ($urandom_range(0, 2) != 0);
      fe_if.fe_queue   = mk(e_instr_fetch, 39'h4000_0000 + 39'(4 * sent));
      fe_if.fe_queue_v = v;
      fe_queue_yumi_i  = y;
      deq_i            = d;
      tick();
      if (d) begin
        void'(sb_q.pop_front());
        iss--;
      end
      if (y) iss++;
      if (v && rdy) begin
        sb_q.push_back(39'h4000_0000 + 39'(4 * sent));
        sent++;
      end
      cyc++;
    end
    fe_if.fe_queue_v = 1'b0;
    fe_queue_yumi_i  = 1'b0;
    deq_i            = 1'b0;
    check("t5_done_in_budget", (sent == 40 && sb_q.size() == 0), 1);
    check("t5_final_empty", empty_o, 1);

    // 6. exception decode and async reset
    fe_if.fe_queue_v = 1'b1;
    fe_if.fe_queue = mk(e_instr_fetch, 39'hc000_0000);
    tick();
    fe_if.fe_queue = mk(e_itlb_miss, 39'hc000_0004);
    tick();
    fe_if.fe_queue_v = 1'b0;
    check("t6_fetch_exc", exception_v_o, 0);
    check("t6_fetch_v", fe_queue_v_o, 1);
    fe_queue_yumi_i = 1'b1;
    tick();
    fe_queue_yumi_i = 1'b0;
    check("t6_itlb_exc", exception_v_o, 1);
    check("t6_itlb_pc", fe_queue_o.pc, 39'hc000_0004);
    fe_if.fe_queue_v = 1'b1;
    fe_if.fe_queue = mk(e_instr_fetch, 39'hc000_0008);
    tick();
    fe_if.fe_queue_v = 1'b0;
    check("t6_count3", count_o, 3);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_rst_v", fe_queue_v_o, 0);
    check("t6_rst_count", count_o, 0);
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_ready", fe_if.fe_queue_ready, 1);
    check("t6_rst_exc", exception_v_o, 0);
    tick();
    reset_i = 1'b0;
    tick();
    check("t6_post_rst_v", fe_queue_v_o, 0);
    check("t6_post_rst_count", count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
